// File: rtl/parking_controller_multi.sv
// Multi-space parking lot controller: entry-gate password FSM, occupancy tracking,
// wrong-password lockout and tailgate detection with registered gate LEDs and lot status.
module parking_controller_multi #(
   parameter int unsigned       CAPACITY    = 8,
   parameter int unsigned       PASS_W      = 2,
   parameter logic [PASS_W-1:0] PASS_CODE_1 = PASS_W'(2'b01),
   parameter logic [PASS_W-1:0] PASS_CODE_2 = PASS_W'(2'b10),
   parameter int unsigned       WAIT_CYCLES = 8,
   parameter int unsigned       MAX_TRIES   = 3,
   parameter int unsigned       LOCK_CYCLES = 16,
   parameter int unsigned       BLINK_DIV   = 2
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              entry_detect,
   input  logic                              gate_pass,
   input  logic                              exit_detect,
   input  logic                              pass_valid,
   input  logic [PASS_W-1:0]                 pass_1,
   input  logic [PASS_W-1:0]                 pass_2,
   output logic                              green_led,
   output logic                              red_led,
   output logic                              full,
   output logic                              locked,
   output logic [$clog2(CAPACITY+1)-1:0]     occupancy
);

   localparam int unsigned OCC_W   = $clog2(CAPACITY + 1);
   localparam int unsigned TMR_MAX = (WAIT_CYCLES > LOCK_CYCLES) ? WAIT_CYCLES : LOCK_CYCLES;
   localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
   localparam int unsigned TRY_W   = $clog2(MAX_TRIES + 1);
   localparam int unsigned BLK_W   = $clog2(BLINK_DIV + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WAIT  = 3'd1;
   localparam logic [2:0] S_WRONG = 3'd2;
   localparam logic [2:0] S_GRANT = 3'd3;
   localparam logic [2:0] S_STOP  = 3'd4;
   localparam logic [2:0] S_LOCK  = 3'd5;

   logic [2:0]       state, state_nxt;
   logic [TRY_W-1:0] tries, tries_nxt, tries_inc;
   logic [TMR_W-1:0] timer, timer_nxt;
   logic [BLK_W-1:0] blink_cnt, blink_cnt_nxt;
   logic             blink, blink_nxt;
   logic [OCC_W-1:0] occ_nxt;
   logic             full_nxt, green_nxt, red_nxt, locked_nxt;
   logic             match, miss, enter, reenter, inc, dec;

   assign match     = pass_valid && (pass_1 == PASS_CODE_1) && (pass_2 == PASS_CODE_2);
   assign miss      = pass_valid && !match;
   assign tries_inc = tries + 1'b1;
   assign inc       = (state == S_GRANT) && gate_pass;
   assign dec       = exit_detect && (occupancy != '0);

   // State, counters and all outputs update together so outputs track the present state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         tries     <= '0;
         timer     <= '0;
         blink_cnt <= '0;
         blink     <= 1'b0;
         occupancy <= '0;
         full      <= 1'b0;
         green_led <= 1'b0;
         red_led   <= 1'b0;
         locked    <= 1'b0;
      end else begin
         state     <= state_nxt;
         tries     <= tries_nxt;
         timer     <= timer_nxt;
         blink_cnt <= blink_cnt_nxt;
         blink     <= blink_nxt;
         occupancy <= occ_nxt;
         full      <= full_nxt;
         green_led <= green_nxt;
         red_led   <= red_nxt;
         locked    <= locked_nxt;
      end
   end

   // Next-state, counter and output-register logic
   always_comb begin
      state_nxt     = state;
      reenter       = 1'b0;
      tries_nxt     = tries;
      timer_nxt     = timer + 1'b1;
      blink_cnt_nxt = blink_cnt;
      blink_nxt     = blink;
      occ_nxt       = occupancy;
      green_nxt     = 1'b0;
      red_nxt       = 1'b0;
      locked_nxt    = 1'b0;

      case (state)
         S_IDLE: begin
            if (entry_detect && !full) state_nxt = S_WAIT;
         end
         S_WAIT, S_WRONG: begin
            if (match) begin
               state_nxt = S_GRANT;
            end else if (miss) begin
               if (tries_inc == TRY_W'(MAX_TRIES)) begin
                  state_nxt = S_LOCK;
               end else begin
                  state_nxt = S_WRONG;
                  reenter   = 1'b1;
                  tries_nxt = tries_inc;
               end
            end else if (timer == TMR_W'(WAIT_CYCLES - 1)) begin
               state_nxt = S_IDLE;
            end
            if (pass_valid) timer_nxt = '0;
         end
         S_GRANT: begin
            if (gate_pass) state_nxt = entry_detect ? S_STOP : S_IDLE;
         end
         S_STOP: begin
            if (match) state_nxt = S_GRANT;
         end
         S_LOCK: begin
            if (timer == TMR_W'(LOCK_CYCLES - 1)) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase

      enter = reenter || (state_nxt != state);
      if (enter) timer_nxt = '0;
      if (enter && ((state_nxt == S_IDLE) || (state_nxt == S_GRANT) || (state_nxt == S_LOCK)))
         tries_nxt = '0;

      // Blink phase restarts high on every entry, then toggles each BLINK_DIV cycles
      if (enter) begin
         blink_cnt_nxt = '0;
         blink_nxt     = 1'b1;
      end else if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
         blink_cnt_nxt = '0;
         blink_nxt     = ~blink;
      end else begin
         blink_cnt_nxt = blink_cnt + 1'b1;
      end

      if (inc && !dec) begin
         if (occupancy != OCC_W'(CAPACITY)) occ_nxt = occupancy + 1'b1;
      end else if (dec && !inc) begin
         occ_nxt = occupancy - 1'b1;
      end
      full_nxt = (occ_nxt == OCC_W'(CAPACITY));

      case (state_nxt)
         S_IDLE:  red_nxt   = full_nxt;
         S_WAIT:  red_nxt   = 1'b1;
         S_WRONG: red_nxt   = blink_nxt;
         S_GRANT: green_nxt = blink_nxt;
         S_STOP:  red_nxt   = blink_nxt;
         S_LOCK: begin
            red_nxt    = 1'b1;
            locked_nxt = 1'b1;
         end
         default: red_nxt = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_parking_controller_multi.sv
// Directed self-checking bench for parking_controller_multi with default parameters.
module tb_parking_controller_multi;

   logic       clk = 1'b0;
   logic       rst_n, entry_detect, gate_pass, exit_detect, pass_valid;
   logic [1:0] pass_1, pass_2;
   logic       green_led, red_led, full, locked;
   logic [3:0] occupancy;
   int         checks   = 0;
   int         failures = 0;

   parking_controller_multi dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .entry_detect (entry_detect),
      .gate_pass    (gate_pass),
      .exit_detect  (exit_detect),
      .pass_valid   (pass_valid),
      .pass_1       (pass_1),
      .pass_2       (pass_2),
      .green_led    (green_led),
      .red_led      (red_led),
      .full         (full),
      .locked       (locked),
      .occupancy    (occupancy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic g, input logic r, input logic f,
                      input logic l, input logic [3:0] occ);
      logic [7:0] obs, expv;
      obs  = {green_led, red_led, full, locked, occupancy};
      expv = {g, r, f, l, occ};
      checks++;
      assert (obs === expv)
      else begin
         failures++;
         $error("FAIL %s observed g/r/f/l/occ=%b expected=%b", tag, obs, expv);
      end
   endtask

   task automatic pv(input logic [1:0] a, input logic [1:0] b);
      pass_valid = 1'b1;
      pass_1     = a;
      pass_2     = b;
      tick();
      pass_valid = 1'b0;
   endtask

   task automatic do_entry(input int exp_occ);
      entry_detect = 1'b1;
      tick();
      entry_detect = 1'b0;
      pv(2'b01, 2'b10);
      gate_pass = 1'b1;
      tick();
      gate_pass = 1'b0;
      chk("entry_cycle", 1'b0, exp_occ == 8, exp_occ == 8, 1'b0, 4'(exp_occ));
   endtask

   initial begin
      rst_n = 1'b0; entry_detect = 1'b0; gate_pass = 1'b0; exit_detect = 1'b0;
      pass_valid = 1'b0; pass_1 = 2'b00; pass_2 = 2'b00;
      #12;
      chk("reset_state", 0, 0, 0, 0, 4'd0);
      rst_n = 1'b1;
      tick();
      chk("idle_after_reset", 0, 0, 0, 0, 4'd0);

      // Correct password, green blink pattern, vehicle enters
      entry_detect = 1'b1;
      tick();
      chk("wait_red", 0, 1, 0, 0, 4'd0);
      tick(); tick();
      chk("wait_red_3", 0, 1, 0, 0, 4'd0);
      pv(2'b01, 2'b10);
      chk("grant_g0", 1, 0, 0, 0, 4'd0);
      tick(); chk("grant_g1", 1, 0, 0, 0, 4'd0);
      tick(); chk("grant_g2", 0, 0, 0, 0, 4'd0);
      tick(); chk("grant_g3", 0, 0, 0, 0, 4'd0);
      tick(); chk("grant_g4", 1, 0, 0, 0, 4'd0);
      entry_detect = 1'b0;
      gate_pass = 1'b1;
      tick();
      gate_pass = 1'b0;
      chk("gate_pass_idle", 0, 0, 0, 0, 4'd1);

      // Wrong passwords, blink restart on re-entry, lockout
      entry_detect = 1'b1;
      tick();
      entry_detect = 1'b0;
      chk("wait2_red", 0, 1, 0, 0, 4'd1);
      pv(2'b11, 2'b10); chk("wrong1_r0", 0, 1, 0, 0, 4'd1);
      tick();           chk("wrong1_r1", 0, 1, 0, 0, 4'd1);
      tick();           chk("wrong1_r2", 0, 0, 0, 0, 4'd1);
      pv(2'b11, 2'b10); chk("wrong2_restart", 0, 1, 0, 0, 4'd1);
      tick();           chk("wrong2_r1", 0, 1, 0, 0, 4'd1);
      pv(2'b11, 2'b10); chk("lock_enter", 0, 1, 0, 1, 4'd1);
      for (int i = 1; i <= 15; i++) begin
         if (i == 5) begin
            pass_valid = 1'b1; pass_1 = 2'b01; pass_2 = 2'b10; entry_detect = 1'b1;
         end
         tick();
         pass_valid = 1'b0; entry_detect = 1'b0;
         chk("lock_hold", 0, 1, 0, 1, 4'd1);
      end
      tick();
      chk("lock_release", 0, 0, 0, 0, 4'd1);

      // Password timeout
      entry_detect = 1'b1;
      tick();
      entry_detect = 1'b0;
      chk("timeout_wait0", 0, 1, 0, 0, 4'd1);
      for (int i = 1; i <= 7; i++) begin
         tick();
         chk("timeout_wait", 0, 1, 0, 0, 4'd1);
      end
      tick();
      chk("timeout_idle", 0, 0, 0, 0, 4'd1);

      // Tailgate to STOP, miss does not restart blink, recovery
      entry_detect = 1'b1;
      tick();
      entry_detect = 1'b0;
      pv(2'b01, 2'b10);
      chk("tg_grant", 1, 0, 0, 0, 4'd1);
      gate_pass = 1'b1; entry_detect = 1'b1;
      tick();
      gate_pass = 1'b0; entry_detect = 1'b0;
      chk("stop_enter", 0, 1, 0, 0, 4'd2);
      tick();           chk("stop_r1", 0, 1, 0, 0, 4'd2);
      tick();           chk("stop_r2", 0, 0, 0, 0, 4'd2);
      pv(2'b11, 2'b10); chk("stop_miss_stay", 0, 0, 0, 0, 4'd2);
      pv(2'b01, 2'b10); chk("stop_to_grant", 1, 0, 0, 0, 4'd2);
      gate_pass = 1'b1;
      tick();
      gate_pass = 1'b0;
      chk("tg_idle", 0, 0, 0, 0, 4'd3);
      gate_pass = 1'b1;
      tick();
      gate_pass = 1'b0;
      chk("gate_pass_outside_grant", 0, 0, 0, 0, 4'd3);

      // Fill the lot, saturation, simultaneous inc/dec
      for (int n = 4; n <= 7; n++) do_entry(n);
      entry_detect = 1'b1;
      tick();
      entry_detect = 1'b0;
      pv(2'b01, 2'b10);
      chk("fill_grant7", 1, 0, 0, 0, 4'd7);
      gate_pass = 1'b1; entry_detect = 1'b1;
      tick();
      gate_pass = 1'b0; entry_detect = 1'b0;
      chk("fill_stop8", 0, 1, 1, 0, 4'd8);
      pv(2'b01, 2'b10); chk("fill_grant8", 1, 0, 1, 0, 4'd8);
      gate_pass = 1'b1; entry_detect = 1'b1;
      tick();
      gate_pass = 1'b0; entry_detect = 1'b0;
      chk("saturate8", 0, 1, 1, 0, 4'd8);
      pv(2'b01, 2'b10); chk("fill_grant8b", 1, 0, 1, 0, 4'd8);
      gate_pass = 1'b1; exit_detect = 1'b1;
      tick();
      gate_pass = 1'b0; exit_detect = 1'b0;
      chk("inc_dec_same", 0, 1, 1, 0, 4'd8);
      entry_detect = 1'b1;
      tick(); tick();
      entry_detect = 1'b0;
      pv(2'b01, 2'b10);
      chk("full_ignores_entry", 0, 1, 1, 0, 4'd8);
      exit_detect = 1'b1;
      tick();
      exit_detect = 1'b0;
      chk("exit_to7", 0, 0, 0, 0, 4'd7);
      for (int n = 6; n >= 0; n--) begin
         exit_detect = 1'b1;
         tick();
         exit_detect = 1'b0;
         chk("drain", 0, 0, 0, 0, 4'(n));
      end
      exit_detect = 1'b1;
      tick();
      exit_detect = 1'b0;
      chk("exit_at_zero", 0, 0, 0, 0, 4'd0);

      // Asynchronous reset in the middle of GRANT
      for (int n = 1; n <= 5; n++) do_entry(n);
      entry_detect = 1'b1;
      tick();
      entry_detect = 1'b0;
      pv(2'b01, 2'b10);
      chk("pre_reset_grant", 1, 0, 0, 0, 4'd5);
      rst_n = 1'b0;
      #2;
      chk("async_reset", 0, 0, 0, 0, 4'd0);
      tick();
      chk("held_reset", 0, 0, 0, 0, 4'd0);
      rst_n = 1'b1;
      tick();
      chk("after_reset_idle", 0, 0, 0, 0, 4'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
